// File: rtl/pipelined_processing_unit.sv
// Pipelined LC-3 style register file + ALU with operand forwarding.
// One issue cycle (operand capture) and one execute/writeback cycle.
module pipelined_processing_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 5
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_VALID,
    input  logic [1:0]        i_ALUK,
    input  logic [ADDR_W-1:0] i_DR,
    input  logic [ADDR_W-1:0] i_SR1,
    input  logic [ADDR_W-1:0] i_SR2,
    input  logic              i_IMM_SEL,
    input  logic [IMM_W-1:0]  i_IMM,
    input  logic              i_LD_REG,
    input  logic              i_LD_CC,
    input  logic              i_BUS_LD,
    input  logic [ADDR_W-1:0] i_BUS_DR,
    input  logic [DATA_W-1:0] i_BUS,
    output logic [DATA_W-1:0] o_RESULT,
    output logic              o_RESULT_VALID,
    output logic              o_N,
    output logic              o_Z,
    output logic              o_P
);

    localparam int NREG = 2 ** ADDR_W;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    logic [DATA_W-1:0] r_rf [NREG];

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [1:0]        r_ex_aluk;
    logic [ADDR_W-1:0] r_ex_dr;
    logic              r_ex_ld_reg;
    logic              r_ex_ld_cc;

    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_n;
    logic              r_z;
    logic              r_p;

    logic [DATA_W-1:0] w_alu;
    logic              w_ex_wr;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_src_a;
    logic [DATA_W-1:0] w_src_b;
    logic [DATA_W-1:0] w_op_b;

    assign w_ex_wr   = r_ex_valid & r_ex_ld_reg;
    assign w_imm_ext = {{(DATA_W-IMM_W){i_IMM[IMM_W-1]}}, i_IMM};
    assign w_op_b    = i_IMM_SEL ? w_imm_ext : w_src_b;

    // ALU on the captured EX operands
    always_comb begin
        w_alu = '0;
        unique case (r_ex_aluk)
            ALU_ADD:  w_alu = r_ex_a + r_ex_b;
            ALU_AND:  w_alu = r_ex_a & r_ex_b;
            ALU_NOT:  w_alu = ~r_ex_a;
            ALU_PASS: w_alu = r_ex_a;
            default:  w_alu = '0;
        endcase
    end

    // Operand A: EX result beats bus load beats register file
    always_comb begin
        w_src_a = r_rf[i_SR1];
        if (w_ex_wr && r_ex_dr == i_SR1)
            w_src_a = w_alu;
        else if (i_BUS_LD && i_BUS_DR == i_SR1)
            w_src_a = i_BUS;
    end

    // Operand B register path, same priority as operand A
    always_comb begin
        w_src_b = r_rf[i_SR2];
        if (w_ex_wr && r_ex_dr == i_SR2)
            w_src_b = w_alu;
        else if (i_BUS_LD && i_BUS_DR == i_SR2)
            w_src_b = i_BUS;
    end

    // Issue: capture forwarded operands and control into EX
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_ex_valid  <= 1'b0;
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_ex_aluk   <= '0;
            r_ex_dr     <= '0;
            r_ex_ld_reg <= 1'b0;
            r_ex_ld_cc  <= 1'b0;
        end else begin
            r_ex_valid <= i_VALID;
            if (i_VALID) begin
                r_ex_a      <= w_src_a;
                r_ex_b      <= w_op_b;
                r_ex_aluk   <= i_ALUK;
                r_ex_dr     <= i_DR;
                r_ex_ld_reg <= i_LD_REG;
                r_ex_ld_cc  <= i_LD_CC;
            end
        end
    end

    // Register file write: EX writeback wins over a bus load to the same reg
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < NREG; i++)
                r_rf[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_ex_wr && r_ex_dr == ADDR_W'(i))
                    r_rf[i] <= w_alu;
                else if (i_BUS_LD && i_BUS_DR == ADDR_W'(i))
                    r_rf[i] <= i_BUS;
            end
        end
    end

    // Result register and one-cycle valid pulse per executed op
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= r_ex_valid;
            if (r_ex_valid)
                r_result <= w_alu;
        end
    end

    // Condition codes from the executed result
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_n <= 1'b0;
            r_z <= 1'b1;
            r_p <= 1'b0;
        end else if (r_ex_valid && r_ex_ld_cc) begin
            r_n <= w_alu[DATA_W-1];
            r_z <= (w_alu == '0);
            r_p <= !w_alu[DATA_W-1] && (w_alu != '0);
        end
    end

    assign o_RESULT       = r_result;
    assign o_RESULT_VALID = r_result_valid;
    assign o_N            = r_n;
    assign o_Z            = r_z;
    assign o_P            = r_p;

endmodule

// File: tb/tb_pipelined_processing_unit.sv
// Bench for pipelined_processing_unit: directed plan plus random ops
// against an architectural (sequential) reference model.
module tb_pipelined_processing_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  aluk;
    logic [2:0]  dr, sr1, sr2;
    logic        imm_sel;
    logic [4:0]  imm;
    logic        ld_reg, ld_cc;
    logic        bus_ld;
    logic [2:0]  bus_dr;
    logic [15:0] bus;
    logic [15:0] result;
    logic        result_valid;
    logic        n, z, p;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] m_rf [8];
    logic [15:0] m_res;
    logic        m_rv;
    logic [2:0]  m_nzp;
    logic        p_valid;
    logic [15:0] p_res;
    logic [2:0]  p_dr;
    logic        p_ldr, p_ldc;

    pipelined_processing_unit dut (
        .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .i_ALUK(aluk),
        .i_DR(dr), .i_SR1(sr1), .i_SR2(sr2), .i_IMM_SEL(imm_sel),
        .i_IMM(imm), .i_LD_REG(ld_reg), .i_LD_CC(ld_cc),
        .i_BUS_LD(bus_ld), .i_BUS_DR(bus_dr), .i_BUS(bus),
        .o_RESULT(result), .o_RESULT_VALID(result_valid),
        .o_N(n), .o_Z(z), .o_P(p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu(input logic [1:0] k,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        case (k)
            2'd0: return 16'((32'(a) + 32'(b)) % 65536);
            2'd1: return a & b;
            2'd2: return ~a;
            default: return a;
        endcase
    endfunction

    // One clock: drive inputs, advance model, check outputs after the edge
    task automatic step(input bit r, input bit v, input logic [1:0] k,
                        input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input bit isel,
                        input logic [4:0] im, input bit ldr,
                        input bit ldc, input bit bld,
                        input logic [2:0] bdr, input logic [15:0] bv);
        logic [15:0] a, b;
        rst = r; valid = v; aluk = k; dr = d; sr1 = s1; sr2 = s2;
        imm_sel = isel; imm = im; ld_reg = ldr; ld_cc = ldc;
        bus_ld = bld; bus_dr = bdr; bus = bv;
        if (r) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
            m_res = 16'h0; m_rv = 1'b0; m_nzp = 3'b010; p_valid = 1'b0;
        end else begin
            m_rv = p_valid;
            if (bld) m_rf[bdr] = bv;
            if (p_valid) begin
                m_res = p_res;
                if (p_ldr) m_rf[p_dr] = p_res;
                if (p_ldc)
                    m_nzp = $signed(p_res) < 0 ? 3'b100 :
                            (p_res == 0 ? 3'b010 : 3'b001);
            end
            p_valid = v;
            if (v) begin
                a = m_rf[s1];
                b = isel ? 16'($signed(im)) : m_rf[s2];
                p_res = alu(k, a, b);
                p_dr = d; p_ldr = ldr; p_ldc = ldc;
            end
        end
        @(posedge clk);
        #1;
        chk("res_valid", 32'(result_valid), 32'(m_rv));
        chk("result", 32'(result), 32'(m_res));
        chk("nzp", 32'({n, z, p}), 32'(m_nzp));
    endtask

    task automatic rst_cyc();
        step(1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 16'hAAAA);
    endtask
    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask
    task automatic busld(input logic [2:0] d, input logic [15:0] v);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, d, v);
    endtask
    task automatic op(input logic [1:0] k, input logic [2:0] d,
                      input logic [2:0] s1, input logic [2:0] s2,
                      input bit ldc);
        step(0, 1, k, d, s1, s2, 0, 0, 1, ldc, 0, 0, 16'h0);
    endtask
    task automatic opi(input logic [2:0] d, input logic [2:0] s1,
                       input logic [4:0] im, input bit ldc);
        step(0, 1, 2'd0, d, s1, 0, 1, im, 1, ldc, 0, 0, 16'h0);
    endtask
    task automatic pass(input logic [2:0] s);
        step(0, 1, 2'd3, 0, s, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        rst = 1; valid = 0; aluk = 0; dr = 0; sr1 = 0; sr2 = 0;
        imm_sel = 0; imm = 0; ld_reg = 0; ld_cc = 0;
        bus_ld = 0; bus_dr = 0; bus = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_res = 0; m_rv = 0; m_nzp = 3'b010; p_valid = 0;
        p_res = 0; p_dr = 0; p_ldr = 0; p_ldc = 0;

        rst_cyc(); rst_cyc();
        chk("rst_nzp", 32'({n, z, p}), 32'h2);
        chk("rst_valid", 32'(result_valid), 32'h0);
        for (int i = 0; i < 8; i++) pass(3'(i));
        idle();

        busld(1, 16'd3); busld(2, 16'd4);
        op(0, 3, 1, 2, 1); idle();
        chk("add_r3", 32'(result), 32'h7);
        chk("add_nzp", 32'({n, z, p}), 32'h1);
        pass(3); idle();
        chk("pass_r3", 32'(result), 32'h7);

        op(0, 3, 1, 2, 0);
        op(0, 4, 1, 3, 0); chk("b2b_1", 32'(result), 32'd7);
        op(0, 3, 4, 3, 0); chk("b2b_2", 32'(result), 32'd10);
        op(0, 7, 4, 3, 0); chk("b2b_3", 32'(result), 32'd17);
        op(0, 4, 4, 7, 0); chk("b2b_4", 32'(result), 32'd27);
        idle();            chk("b2b_5", 32'(result), 32'd37);

        busld(1, 16'd3);
        opi(1, 1, 5'd8, 0);
        opi(1, 1, 5'd8, 0); chk("inc_1", 32'(result), 32'd11);
        opi(1, 1, 5'd8, 0); chk("inc_2", 32'(result), 32'd19);
        idle();             chk("inc_3", 32'(result), 32'd27);
        idle();             chk("inc_once", 32'(result_valid), 32'h0);
        pass(1); idle();    chk("inc_r1", 32'(result), 32'd27);

        busld(2, 16'd4);
        opi(0, 2, 5'b10000, 1); idle();
        chk("neg_imm", 32'(result), 32'hFFF4);
        chk("neg_nzp", 32'({n, z, p}), 32'h4);
        busld(5, 16'hFFFF);
        op(2, 6, 5, 0, 1); idle();
        chk("not_res", 32'(result), 32'h0);
        chk("not_nzp", 32'({n, z, p}), 32'h2);

        busld(1, 16'd4); busld(2, 16'd5);
        op(0, 5, 1, 2, 1);
        busld(5, 16'h55);
        op(0, 5, 1, 2, 1);
        busld(6, 16'h55);
        pass(5); pass(6);  chk("col_r5", 32'(result), 32'd9);
        idle();            chk("col_r6", 32'(result), 32'h55);

        busld(1, 16'd3);
        op(0, 2, 1, 1, 1);
        rst_cyc();
        chk("rst_fly_v", 32'(result_valid), 32'h0);
        chk("rst_fly_nzp", 32'({n, z, p}), 32'h2);
        pass(2); idle();
        chk("rst_fly_r2", 32'(result), 32'h0);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 60) == 0) rst_cyc();
            else step(0, 1'($urandom), 2'($urandom), 3'($urandom),
                      3'($urandom), 3'($urandom), 1'($urandom),
                      5'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 3'($urandom), 16'($urandom));
        end
        for (int i = 0; i < 8; i++) pass(3'(i));
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
